uart_rx_v_2: RTL and testbench

- UART receiver; the receive-side counterpart of the team's UART transmitter.
- Recovers frames of 1 start bit, WORD_LENGTH data bits (LSB first), 1 even-parity bit and 1 stop bit from the serial line.
- Presents each good word to the APB side with a valid/acknowledge handshake.
- Flags parity and framing errors to the transmitter over err_ack, plus status outputs.

---
 rtl/uart_rx_v_2.sv | 168 ++++++++++++++++
 tb/tb_uart_rx_v_2.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_v_2.sv
// UART receiver: 2-flop synchroniser, mid-bit sampling, 8E1 framing, valid/ack hand-off of each good word.
// Word lands one clock after the mid-stop sample; an unread word blocks new ones (dropped, sticky overrun).
module uart_rx_v_2 #(
  parameter int WORD_LENGTH      = 8,
  parameter int BAUD_COUNTER_MAX = 434,
  parameter int HALF_BIT         = BAUD_COUNTER_MAX / 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   UART_Rx_IN,
  input  logic                   Rx_READ_ACK,
  output logic [WORD_LENGTH-1:0] Rx_DATA,
  output logic                   Rx_VALID,
  output logic                   Rx_PARITY_ERR,
  output logic                   Rx_FRAME_ERR,
  output logic                   Rx_OVERRUN,
  output logic                   err_ack
);

  localparam int CW = $clog2(BAUD_COUNTER_MAX) + 1;
  localparam int IW = $clog2(WORD_LENGTH + 1);

  localparam logic [CW-1:0] C_HALF = CW'(HALF_BIT);
  localparam logic [CW-1:0] C_MAX  = CW'(BAUD_COUNTER_MAX);
  localparam logic [IW-1:0] I_PAR  = IW'(WORD_LENGTH);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_STOP      = 3'd3;
  localparam logic [2:0] S_WAIT_HIGH = 3'd4;

  logic                 r_sync1;
  logic                 r_sync2;
  logic [2:0]           r_state;
  logic [CW-1:0]        r_cnt;
  logic [IW-1:0]        r_idx;
  logic [WORD_LENGTH:0] r_shift;
  logic                 r_good;

  logic                 w_rxs;
  logic [2:0]           w_state_nxt;
  logic [CW-1:0]        w_cnt_nxt;
  logic [IW-1:0]        w_idx_nxt;
  logic [WORD_LENGTH:0] w_shift_nxt;
  logic                 w_good;
  logic                 w_perr;
  logic                 w_ferr;
  logic                 w_load;

  assign w_rxs  = r_sync2;
  assign w_load = r_good && (!Rx_VALID || Rx_READ_ACK);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= UART_Rx_IN;
      r_sync2 <= r_sync1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 1'b1;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_good      = 1'b0;
    w_perr      = 1'b0;
    w_ferr      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (!w_rxs) w_state_nxt = S_START;
      end
      S_START: begin
        if (r_cnt == C_HALF) begin
          w_cnt_nxt = '0;
          if (!w_rxs) begin
            w_state_nxt = S_DATA;
            w_idx_nxt   = '0;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (r_cnt == C_MAX) begin
          w_cnt_nxt          = '0;
          w_shift_nxt[r_idx] = w_rxs;
          if (r_idx == I_PAR) w_state_nxt = S_STOP;
          else                w_idx_nxt   = r_idx + 1'b1;
        end
      end
      S_STOP: begin
        if (r_cnt == C_MAX) begin
          w_cnt_nxt = '0;
          if (w_rxs) begin
            // Leaving at mid-stop lets an immediately following start edge be caught.
            w_state_nxt = S_IDLE;
            if (^r_shift == 1'b0) w_good = 1'b1;
            else                  w_perr = 1'b1;
          end else begin
            w_state_nxt = S_WAIT_HIGH;
            w_ferr      = 1'b1;
          end
        end
      end
      S_WAIT_HIGH: begin
        w_cnt_nxt = '0;
        if (w_rxs) w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
    if (w_state_nxt != r_state) w_cnt_nxt = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_good        <= 1'b0;
      Rx_PARITY_ERR <= 1'b0;
      Rx_FRAME_ERR  <= 1'b0;
      err_ack       <= 1'b0;
    end else begin
      r_good        <= w_good;
      Rx_PARITY_ERR <= w_perr;
      Rx_FRAME_ERR  <= w_ferr;
      err_ack       <= w_perr | w_ferr;
    end
  end

  // The shift register is still intact one clock after the stop sample (state is IDLE).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      Rx_DATA    <= '0;
      Rx_VALID   <= 1'b0;
      Rx_OVERRUN <= 1'b0;
    end else if (w_load) begin
      Rx_DATA  <= r_shift[WORD_LENGTH-1:0];
      Rx_VALID <= 1'b1;
      if (Rx_READ_ACK) Rx_OVERRUN <= 1'b0;
    end else if (r_good) begin
      Rx_OVERRUN <= 1'b1;
    end else if (Rx_READ_ACK) begin
      Rx_VALID   <= 1'b0;
      Rx_OVERRUN <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_v_2.sv
// Randomised self-checking bench for uart_rx_v_2 against a frame-level reference model.
module tb_uart_rx_v_2;

  localparam int BIT   = 435;
  localparam int FRAME = 11 * BIT;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       UART_Rx_IN = 1'b1;
  logic       Rx_READ_ACK = 1'b0;
  logic [7:0] Rx_DATA;
  logic       Rx_VALID, Rx_PARITY_ERR, Rx_FRAME_ERR, Rx_OVERRUN, err_ack;

  uart_rx_v_2 dut (
    .clk(clk), .rst(rst), .UART_Rx_IN(UART_Rx_IN), .Rx_READ_ACK(Rx_READ_ACK),
    .Rx_DATA(Rx_DATA), .Rx_VALID(Rx_VALID), .Rx_PARITY_ERR(Rx_PARITY_ERR),
    .Rx_FRAME_ERR(Rx_FRAME_ERR), .Rx_OVERRUN(Rx_OVERRUN), .err_ack(err_ack)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // Reference model state
  logic [7:0] m_data = 8'h00;
  logic       m_valid = 1'b0;
  logic       m_overrun = 1'b0;
  int         exp_perr = 0, exp_ferr = 0, exp_rise = 0;
  int         load_ack_c = -1;

  // Output monitor: pulse-cycle counts and word-arrival count
  int   perr_cnt = 0, ferr_cnt = 0, rise_cnt = 0, ackbad_cnt = 0;
  logic mon_pv = 1'b0;
  always @(negedge clk) begin
    if (Rx_PARITY_ERR === 1'b1) perr_cnt++;
    if (Rx_FRAME_ERR === 1'b1) ferr_cnt++;
    if (err_ack !== (Rx_PARITY_ERR | Rx_FRAME_ERR)) ackbad_cnt++;
    if (Rx_VALID === 1'b1 && mon_pv == 1'b0) rise_cnt++;
    mon_pv = (Rx_VALID === 1'b1);
  end

  task automatic model_frame(input logic [7:0] d, input logic p, input logic s, input logic acked);
    logic good;
    good = s && ((^d ^ p) == 1'b0);
    if (!s) exp_ferr++;
    else if (!good) exp_perr++;
    if (good) begin
      if (!m_valid || acked) begin
        if (!m_valid) exp_rise++;
        m_data  = d;
        m_valid = 1'b1;
        if (acked) m_overrun = 1'b0;
      end else begin
        m_overrun = 1'b1;
      end
    end
  endtask

  task automatic model_ack();
    m_valid   = 1'b0;
    m_overrun = 1'b0;
  endtask

  // One frame, bit period BIT clocks, start edge at c=0; ack pulsed at clock ack_at (-1: none).
  task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                            input int ack_at, output int rise_c);
    logic [10:0] fr;
    logic        pv;
    fr     = {s, p, d, 1'b0};
    rise_c = -1;
    pv     = Rx_VALID;
    for (int c = 0; c < FRAME; c++) begin
      @(negedge clk);
      if (rise_c < 0 && Rx_VALID === 1'b1 && !pv) rise_c = c;
      pv          = Rx_VALID;
      UART_Rx_IN  = fr[c / BIT];
      Rx_READ_ACK = (c == ack_at);
    end
  endtask

  task automatic idle(input int n);
    UART_Rx_IN = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_ack();
    @(negedge clk); Rx_READ_ACK = 1'b1;
    @(negedge clk); Rx_READ_ACK = 1'b0;
    model_ack();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_chk++; if ({Rx_DATA, Rx_VALID, Rx_OVERRUN} !== 10'd0) $display("FAIL reset_data got %h/%b/%b want 0", Rx_DATA, Rx_VALID, Rx_OVERRUN); else n_pass++;
    n_chk++; if ({Rx_PARITY_ERR, Rx_FRAME_ERR, err_ack} !== 3'd0) $display("FAIL reset_err got %b%b%b want 000", Rx_PARITY_ERR, Rx_FRAME_ERR, err_ack); else n_pass++;
    @(negedge clk); rst = 1'b1;
    idle(20);
  endtask

  task automatic test_good_frame();
    int rc;
    send_frame(8'hA5, 1'b0, 1'b1, -1, rc);
    model_frame(8'hA5, 1'b0, 1'b1, 1'b0);
    idle(10); #1;
    n_chk++; if (Rx_DATA !== 8'hA5) $display("FAIL good_data got %h want a5", Rx_DATA); else n_pass++;
    n_chk++; if (Rx_VALID !== 1'b1) $display("FAIL good_valid got %b want 1", Rx_VALID); else n_pass++;
    n_chk++; if (perr_cnt + ferr_cnt !== 0) $display("FAIL good_noerr got %0d want 0", perr_cnt + ferr_cnt); else n_pass++;
    // Nominal 4570 clocks from the line edge, +-1, plus half a clock of negedge drive/sample skew.
    n_chk++; if (rc < 4569 || rc > 4572) $display("FAIL good_latency got %0d want 4569..4572", rc); else n_pass++;
    load_ack_c = rc - 1;
    pulse_ack();
    @(negedge clk); #1;
    n_chk++; if (Rx_VALID !== m_valid) $display("FAIL good_ack got %b want %b", Rx_VALID, m_valid); else n_pass++;
  endtask

  task automatic test_parity_error();
    int rc;
    send_frame(8'h3C, 1'b1, 1'b1, -1, rc);
    model_frame(8'h3C, 1'b1, 1'b1, 1'b0);
    idle(10); #1;
    n_chk++; if (perr_cnt !== exp_perr) $display("FAIL par_pulse got %0d want %0d", perr_cnt, exp_perr); else n_pass++;
    n_chk++; if (ackbad_cnt !== 0) $display("FAIL par_errack got %0d want 0", ackbad_cnt); else n_pass++;
    n_chk++; if ({Rx_VALID, Rx_DATA} !== {m_valid, m_data}) $display("FAIL par_nodata got %b/%h want %b/%h", Rx_VALID, Rx_DATA, m_valid, m_data); else n_pass++;
  endtask

  task automatic test_framing_error();
    int rc;
    send_frame(8'h55, 1'b0, 1'b0, -1, rc);
    model_frame(8'h55, 1'b0, 1'b0, 1'b0);
    UART_Rx_IN = 1'b0;
    repeat (3 * BIT) @(negedge clk);
    idle(20); #1;
    n_chk++; if (ferr_cnt !== exp_ferr) $display("FAIL frm_pulse got %0d want %0d", ferr_cnt, exp_ferr); else n_pass++;
    n_chk++; if (rise_cnt !== exp_rise || perr_cnt !== exp_perr) $display("FAIL frm_false got %0d/%0d want %0d/%0d", rise_cnt, perr_cnt, exp_rise, exp_perr); else n_pass++;
    send_frame(8'h12, 1'b0, 1'b1, -1, rc);
    model_frame(8'h12, 1'b0, 1'b1, 1'b0);
    idle(10); #1;
    n_chk++; if ({Rx_VALID, Rx_DATA} !== {1'b1, 8'h12}) $display("FAIL frm_next got %b/%h want 1/12", Rx_VALID, Rx_DATA); else n_pass++;
    n_chk++; if (ackbad_cnt !== 0) $display("FAIL frm_errack got %0d want 0", ackbad_cnt); else n_pass++;
  endtask

  task automatic test_glitch();
    UART_Rx_IN = 1'b0;
    repeat (100) @(negedge clk);
    idle(600); #1;
    n_chk++; if (rise_cnt !== exp_rise || {Rx_VALID, Rx_DATA} !== {m_valid, m_data}) $display("FAIL glitch_data got %b/%h want %b/%h", Rx_VALID, Rx_DATA, m_valid, m_data); else n_pass++;
    n_chk++; if (perr_cnt !== exp_perr || ferr_cnt !== exp_ferr) $display("FAIL glitch_err got %0d/%0d want %0d/%0d", perr_cnt, ferr_cnt, exp_perr, exp_ferr); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int rc;
    if (m_valid) pulse_ack();
    send_frame(8'h11, 1'b0, 1'b1, -1, rc);
    model_frame(8'h11, 1'b0, 1'b1, 1'b0);
    send_frame(8'h22, 1'b0, 1'b1, -1, rc);
    model_frame(8'h22, 1'b0, 1'b1, 1'b0);
    idle(10); #1;
    n_chk++; if (Rx_DATA !== 8'h11) $display("FAIL ovr_data got %h want 11", Rx_DATA); else n_pass++;
    n_chk++; if ({Rx_VALID, Rx_OVERRUN} !== {m_valid, m_overrun}) $display("FAIL ovr_flags got %b%b want %b%b", Rx_VALID, Rx_OVERRUN, m_valid, m_overrun); else n_pass++;
    pulse_ack();
    @(negedge clk); #1;
    n_chk++; if ({Rx_VALID, Rx_OVERRUN} !== 2'b00) $display("FAIL ovr_ack got %b%b want 00", Rx_VALID, Rx_OVERRUN); else n_pass++;
    send_frame(8'h11, 1'b0, 1'b1, -1, rc);
    model_frame(8'h11, 1'b0, 1'b1, 1'b0);
    send_frame(8'h22, 1'b0, 1'b1, load_ack_c, rc);
    model_frame(8'h22, 1'b0, 1'b1, 1'b1);
    idle(10); #1;
    n_chk++; if ({Rx_VALID, Rx_OVERRUN, Rx_DATA} !== {1'b1, 1'b0, 8'h22}) $display("FAIL simack got %b%b/%h want 10/22", Rx_VALID, Rx_OVERRUN, Rx_DATA); else n_pass++;
  endtask

  task automatic test_random();
    int         rc;
    logic [7:0] d;
    logic       bad_p, bad_s;
    for (int i = 0; i < 3; i++) begin
      d     = 8'($urandom);
      bad_p = (i != 2) && ($urandom_range(0, 3) == 0);
      bad_s = (i != 2) && !bad_p && ($urandom_range(0, 4) == 0);
      send_frame(d, ^d ^ bad_p, !bad_s, -1, rc);
      model_frame(d, ^d ^ bad_p, !bad_s, 1'b0);
      idle(30); #1;
      n_chk++; if ({Rx_VALID, Rx_OVERRUN, Rx_DATA} !== {m_valid, m_overrun, m_data}) $display("FAIL rand_out[%0d] got %b%b/%h want %b%b/%h", i, Rx_VALID, Rx_OVERRUN, Rx_DATA, m_valid, m_overrun, m_data); else n_pass++;
      n_chk++; if (perr_cnt !== exp_perr || ferr_cnt !== exp_ferr || rise_cnt !== exp_rise) $display("FAIL rand_evt[%0d] got %0d/%0d/%0d want %0d/%0d/%0d", i, perr_cnt, ferr_cnt, rise_cnt, exp_perr, exp_ferr, exp_rise); else n_pass++;
      if (i != 2 && $urandom_range(0, 1) == 1) pulse_ack();
    end
  endtask

  task automatic test_reset_mid_frame();
    int          rc;
    logic [10:0] fr;
    fr = {1'b1, 1'b0, 8'h7E, 1'b0};
    for (int c = 0; c < 5 * BIT + 200; c++) begin
      @(negedge clk);
      UART_Rx_IN = fr[c / BIT];
    end
    @(negedge clk); rst = 1'b0;
    #1;
    n_chk++; if ({Rx_DATA, Rx_VALID, Rx_OVERRUN, Rx_PARITY_ERR, Rx_FRAME_ERR, err_ack} !== 13'd0) $display("FAIL rst_async got %h/%b%b%b%b%b want 0", Rx_DATA, Rx_VALID, Rx_OVERRUN, Rx_PARITY_ERR, Rx_FRAME_ERR, err_ack); else n_pass++;
    m_data = 8'h00;
    model_ack();
    UART_Rx_IN = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    idle(1000); #1;
    n_chk++; if (rise_cnt !== exp_rise || perr_cnt !== exp_perr || ferr_cnt !== exp_ferr) $display("FAIL rst_partial got %0d/%0d/%0d want %0d/%0d/%0d", rise_cnt, perr_cnt, ferr_cnt, exp_rise, exp_perr, exp_ferr); else n_pass++;
    send_frame(8'h7E, 1'b0, 1'b1, -1, rc);
    model_frame(8'h7E, 1'b0, 1'b1, 1'b0);
    idle(10); #1;
    n_chk++; if ({Rx_VALID, Rx_DATA} !== {1'b1, 8'h7E}) $display("FAIL rst_next got %b/%h want 1/7e", Rx_VALID, Rx_DATA); else n_pass++;
    n_chk++; if (ackbad_cnt !== 0) $display("FAIL errack_total got %0d want 0", ackbad_cnt); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_parity_error();
    test_framing_error();
    test_glitch();
    test_back_to_back();
    test_random();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
